// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the CPU pipeline, the data cache and the word-organised data memory.
// The hit/miss counter outputs exist only when DCACHE_STATS_EN is defined.
interface dcache_ctrl_if;
    logic        i_read;
    logic        i_write;
    logic [7:0]  i_address;
    logic [7:0]  i_writedata;
    logic [7:0]  o_readdata;
    logic        o_busywait;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [5:0]  o_mem_address;
    logic [31:0] o_mem_writedata;
    logic [31:0] i_mem_readdata;
    logic        i_mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [7:0]  o_hit_count;
    logic [7:0]  o_miss_count;
`endif

    modport slave (
        input  i_read, i_write, i_address, i_writedata, i_mem_readdata, i_mem_busywait,
`ifdef DCACHE_STATS_EN
        output o_hit_count, o_miss_count,
`endif
        output o_readdata, o_busywait, o_mem_read, o_mem_write, o_mem_address, o_mem_writedata
    );

    modport master (
        output i_read, i_write, i_address, i_writedata, i_mem_readdata, i_mem_busywait,
`ifdef DCACHE_STATS_EN
        input  o_hit_count, o_miss_count,
`endif
        input  o_readdata, o_busywait, o_mem_read, o_mem_write, o_mem_address, o_mem_writedata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller (8 lines x 4 bytes) in front of word memory.
// Optional hit/miss statistics counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_ctrl_if.slave  bus
);
    localparam int TAG_BITS  = 8 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int LINE_BITS = 8 << OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [LINE_BITS-1:0]  r_data [LINES];

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [OFFSET_BITS-1:0] w_offset;
    logic [LINE_BITS-1:0]   w_line;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_busy;
    logic                   w_writeHit;

    assign w_tag      = bus.i_address[7 -: TAG_BITS];
    assign w_index    = bus.i_address[OFFSET_BITS +: INDEX_BITS];
    assign w_offset   = bus.i_address[OFFSET_BITS-1:0];
    assign w_line     = r_data[w_index];
    assign w_req      = bus.i_read | bus.i_write;
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_writeHit = (r_state == IDLE) && bus.i_write && w_hit;

    assign bus.o_readdata = w_line[{w_offset, 3'b000} +: 8];
    // Stall is forced low while reset is held so the CPU is never frozen by a dead FSM.
    assign bus.o_busywait = rst_n & w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState         = r_state;
        w_busy              = 1'b0;
        bus.o_mem_read      = 1'b0;
        bus.o_mem_write     = 1'b0;
        bus.o_mem_address   = '0;
        bus.o_mem_writedata = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_busy      = 1'b1;
                    w_nextState = (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                w_busy              = w_req;
                bus.o_mem_write     = 1'b1;
                bus.o_mem_address   = {r_tag[w_index], w_index};
                bus.o_mem_writedata = w_line;
                if (!bus.i_mem_busywait) w_nextState = FETCH;
            end
            FETCH: begin
                w_busy            = w_req;
                bus.o_mem_read    = 1'b1;
                bus.o_mem_address = {w_tag, w_index};
                if (!bus.i_mem_busywait) w_nextState = UPDATE;
            end
            UPDATE: begin
                w_busy      = w_req;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Data and tag storage carry no reset; only valid/dirty define line ownership.
    always_ff @(posedge clk) begin
        if (r_state == UPDATE) begin
            r_data[w_index] <= bus.i_mem_readdata;
            r_tag[w_index]  <= w_tag;
        end else if (w_writeHit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= bus.i_writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == UPDATE) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_writeHit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic       r_postUpdate;
    logic [7:0] r_hitCount;
    logic [7:0] r_missCount;

    // The re-evaluation hit right after a fill belongs to the miss, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_postUpdate <= 1'b0;
            r_hitCount   <= '0;
            r_missCount  <= '0;
        end else begin
            r_postUpdate <= (r_state == UPDATE);
            if ((r_state == IDLE) && (w_nextState != IDLE) && (r_missCount != 8'hFF))
                r_missCount <= r_missCount + 8'd1;
            if ((r_state == IDLE) && w_req && w_hit && !r_postUpdate && (r_hitCount != 8'hFF))
                r_hitCount <= r_hitCount + 8'd1;
        end
    end

    assign bus.o_hit_count  = r_hitCount;
    assign bus.o_miss_count = r_missCount;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized accesses against a line-level cache model.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();
    dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Word-organised data memory with a programmable number of busy cycles per transaction.
    logic [31:0] memArr [64];
    logic        memLoaded  = 1'b0;
    int          memLat     = 0;
    int          memCount   = 0;
    int          rdCycles   = 0;
    logic [31:0] memRdData  = '0;
    logic [5:0]  lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    logic [5:0]  lastRdAddr = '0;

    function automatic logic [31:0] initWord(input int i);
        if (i == 0) return 32'h44332211;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign bus.i_mem_busywait = (bus.o_mem_read | bus.o_mem_write) && (memCount != memLat);
    assign bus.i_mem_readdata = memRdData;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 64; i++) memArr[i] <= initWord(i);
            memLoaded <= 1'b1;
        end
        if (bus.o_mem_read) rdCycles <= rdCycles + 1;
        if (bus.o_mem_read || bus.o_mem_write) begin
            if (memCount == memLat) begin
                memCount <= 0;
                if (bus.o_mem_write) begin
                    memArr[bus.o_mem_address] <= bus.o_mem_writedata;
                    lastWrAddr <= bus.o_mem_address;
                    lastWrData <= bus.o_mem_writedata;
                end
                if (bus.o_mem_read) begin
                    memRdData  <= memArr[bus.o_mem_address];
                    lastRdAddr <= bus.o_mem_address;
                end
            end else begin
                memCount <= memCount + 1;
            end
        end else begin
            memCount <= 0;
        end
    end

    // Reference model: cache lines, backing memory image and statistics.
    logic        mValid [8];
    logic        mDirty [8];
    logic [2:0]  mTag   [8];
    logic [31:0] mData  [8];
    logic [31:0] refMem [64];
    int          hitCnt  = 0;
    int          missCnt = 0;

    logic        chkEn = 1'b0;
    logic        eBusy, eMrd, eMwr, eRdChk;
    logic [5:0]  eMaddr;
    logic [31:0] eMwd;
    logic [7:0]  eRd;
    int          passCount  = 0;
    int          totalCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of the DUT against the model's expectations, sampled mid-cycle.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("busywait",      32'(bus.o_busywait),    32'(eBusy));
            checkOutput("mem_read",      32'(bus.o_mem_read),    32'(eMrd));
            checkOutput("mem_write",     32'(bus.o_mem_write),   32'(eMwr));
            checkOutput("mem_address",   32'(bus.o_mem_address), 32'(eMaddr));
            checkOutput("mem_writedata", bus.o_mem_writedata,    eMwd);
            if (eRdChk) checkOutput("readdata", 32'(bus.o_readdata), 32'(eRd));
        end
    end

    task automatic setExp(input logic busy, input logic mrd, input logic mwr, input logic [5:0] maddr,
                          input logic [31:0] mwd, input logic rdChk, input logic [7:0] rd);
        eBusy = busy; eMrd = mrd; eMwr = mwr; eMaddr = maddr; eMwd = mwd; eRdChk = rdChk; eRd = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byteOf(input logic [31:0] w, input logic [1:0] off);
        return w[{off, 3'b000} +: 8];
    endfunction

    task automatic modelHitCycle(input logic [2:0] idx, input logic [1:0] off, input logic wr, input logic [7:0] wd);
        setExp(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, byteOf(mData[idx], off));
        step();
        if (wr) begin
            mData[idx][{off, 3'b000} +: 8] = wd;
            mDirty[idx] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                                 input int lat, input logic drop);
        logic [2:0] idx;
        logic [2:0] tg;
        logic [1:0] off;
        logic       req;
        idx = addr[4:2];
        tg  = addr[7:5];
        off = addr[1:0];
        req = rd | wr;
        memLat = lat;
        bus.i_read = rd; bus.i_write = wr; bus.i_address = addr; bus.i_writedata = wd;
        if (mValid[idx] && (mTag[idx] == tg)) begin
            modelHitCycle(idx, off, wr, wd);
            if (hitCnt < 255) hitCnt++;
        end else begin
            if (missCnt < 255) missCnt++;
            setExp(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);
            step();
            if (mValid[idx] && mDirty[idx]) begin
                for (int k = 0; k <= lat; k++) begin
                    setExp(1'b1, 1'b0, 1'b1, {mTag[idx], idx}, mData[idx], 1'b0, 8'd0);
                    step();
                end
                refMem[{mTag[idx], idx}] = mData[idx];
            end
            for (int k = 0; k <= lat; k++) begin
                if (drop && k == 0) begin
                    bus.i_read = 1'b0; bus.i_write = 1'b0; req = 1'b0;
                end
                setExp(req, 1'b1, 1'b0, {tg, idx}, 32'd0, 1'b0, 8'd0);
                step();
            end
            setExp(req, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);
            step();
            mData[idx] = refMem[{tg, idx}]; mTag[idx] = tg; mValid[idx] = 1'b1; mDirty[idx] = 1'b0;
            if (req) begin
                modelHitCycle(idx, off, wr, wd);
            end else begin
                setExp(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);
                step();
            end
        end
    endtask

    task automatic idleCycle();
        bus.i_read = 1'b0; bus.i_write = 1'b0;
        setExp(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: bench did not finish within its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r0;
        logic [2:0] t;
        int op;
        for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
        for (int i = 0; i < 8; i++) begin mValid[i] = 1'b0; mDirty[i] = 1'b0; mTag[i] = '0; mData[i] = 'x; end
        bus.i_read = 1'b1; bus.i_write = 1'b0; bus.i_address = 8'h00; bus.i_writedata = 8'h00;
        setExp(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busywait",      32'(bus.o_busywait),    32'd0);
        checkOutput("reset_mem_read",      32'(bus.o_mem_read),    32'd0);
        checkOutput("reset_mem_write",     32'(bus.o_mem_write),   32'd0);
        checkOutput("reset_mem_address",   32'(bus.o_mem_address), 32'd0);
        checkOutput("reset_mem_writedata", bus.o_mem_writedata,    32'd0);
`ifdef DCACHE_STATS_EN
        checkOutput("reset_hit_count",  32'(bus.o_hit_count),  32'd0);
        checkOutput("reset_miss_count", 32'(bus.o_miss_count), 32'd0);
`endif
        rst_n = 1'b1;
        chkEn = 1'b1;

        // Cold read miss of word 0, then a hit on its top byte with no memory traffic.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 2, 1'b0);
        checkOutput("t1_readdata_0x00", 32'(bus.o_readdata), 32'h11);
        checkOutput("t1_fetch_address", 32'(lastRdAddr), 32'h00);
        r0 = rdCycles;
        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 2, 1'b0);
        checkOutput("t1_readdata_0x03", 32'(bus.o_readdata), 32'h44);
        checkOutput("t1_hit_no_memread", 32'(rdCycles - r0), 32'd0);

        // Write hit dirties line 0 without touching memory.
        applyStimulus(1'b0, 1'b1, 8'h01, 8'hAB, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 2, 1'b0);
        checkOutput("t2_readback_0x01", 32'(bus.o_readdata), 32'hAB);
        checkOutput("t2_memory_untouched", memArr[0], 32'h44332211);

        // Conflict miss on index 0 evicts the dirty line first.
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1, 1'b0);
        checkOutput("t3_wb_address", 32'(lastWrAddr), 32'h00);
        checkOutput("t3_wb_data", lastWrData, 32'h4433AB11);
        checkOutput("t3_fetch_address", 32'(lastRdAddr), 32'h08);
        checkOutput("t3_memory_word0", memArr[0], 32'h4433AB11);

        // Slow memory: five busy cycles plus the releasing cycle in FETCH.
        r0 = rdCycles;
        applyStimulus(1'b1, 1'b0, 8'h44, 8'h00, 5, 1'b0);
        checkOutput("t4_memread_cycles", 32'(rdCycles - r0), 32'd6);

        // Reset in the middle of a fetch abandons it; the line stays invalid.
        memLat = 5;
        bus.i_read = 1'b1; bus.i_write = 1'b0; bus.i_address = 8'h48;
        setExp(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0);
        step();
        setExp(1'b1, 1'b1, 1'b0, 6'h12, 32'd0, 1'b0, 8'd0);
        step();
        chkEn = 1'b0;
        #1;
        checkOutput("t5_memread_before_reset", 32'(bus.o_mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_memread_in_reset", 32'(bus.o_mem_read), 32'd0);
        checkOutput("t5_busywait_in_reset", 32'(bus.o_busywait), 32'd0);
        checkOutput("t5_mem_address_in_reset", 32'(bus.o_mem_address), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin mValid[i] = 1'b0; mDirty[i] = 1'b0; end
        hitCnt = 0; missCnt = 0;
        #1;
        checkOutput("t5_miss_again", 32'(bus.o_busywait), 32'd1);
        chkEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h48, 8'h00, 1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h48, 8'h00, 1, 1'b0);
`ifdef DCACHE_STATS_EN
        checkOutput("t6_miss_count", 32'(bus.o_miss_count), 32'd1);
        checkOutput("t6_hit_count",  32'(bus.o_hit_count),  32'd3);
`endif

        // Randomized traffic, biased to a few tags so hits, conflicts and dirty evictions all occur.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                idleCycle();
            end else begin
                t  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
                op = $urandom_range(0, 2);
                applyStimulus(op != 1, op != 0, {t, 5'($urandom_range(0, 31))}, 8'($urandom),
                              $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            end
        end
        idleCycle();
        chkEn = 1'b0;
`ifdef DCACHE_STATS_EN
        checkOutput("final_hit_count",  32'(bus.o_hit_count),  32'(hitCnt));
        checkOutput("final_miss_count", 32'(bus.o_miss_count), 32'(missCnt));
`endif
        for (int i = 0; i < 64; i++) checkOutput($sformatf("mem_word_%0d", i), memArr[i], refMem[i]);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
